// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit and the datapath forwarding muxes.
package hazard_pkg;

    // ALU operand source selects used by the E-stage forwarding muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/mdu_tracker.sv
// Tracks the multi-cycle mul/div unit: busy window, last-cycle pulse, sticky overlap error.
module mdu_tracker #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] LAT_VAL = CW'(MDU_LAT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // A start while busy is dropped; the running count is never reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_start && !o_busy) begin
                r_cnt <= LAT_VAL;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - ONE;
            end
            if (i_start && o_busy) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == ONE);
    assign o_err  = r_err;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with MDU tracking and a stall counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int FWD_W   = 2,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_rs_d,
    input  logic [REG_AW-1:0] i_rt_d,
    input  logic [REG_AW-1:0] i_rs_e,
    input  logic [REG_AW-1:0] i_rt_e,
    input  logic [REG_AW-1:0] i_wreg_e,
    input  logic [REG_AW-1:0] i_wreg_m,
    input  logic [REG_AW-1:0] i_wreg_w,
    input  logic              i_regwr_e,
    input  logic              i_regwr_m,
    input  logic              i_regwr_w,
    input  logic              i_mem2reg_e,
    input  logic              i_mem2reg_m,
    input  logic              i_branch_d,
    input  logic              i_pcsrc_d,
    input  logic              i_mdu_op_d,
    input  logic              i_mdu_start_e,
    input  logic              i_hilo_rd_d,
    output logic [FWD_W-1:0]  o_fwd_a_e,
    output logic [FWD_W-1:0]  o_fwd_b_e,
    output logic              o_fwd_a_d,
    output logic              o_fwd_b_d,
    output logic              o_stall_f,
    output logic              o_stall_d,
    output logic              o_flush_d,
    output logic              o_flush_e,
    output logic              o_mdu_busy,
    output logic              o_mdu_done,
    output logic              o_mdu_err,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_lw_stall;
    logic             w_br_stall;
    logic             w_mdu_stall;
    logic             w_stall_any;
    logic             w_e_hits_d;
    logic             w_m_hits_d;
    logic [CNT_W-1:0] r_stall_cnt;

    // M-stage results are newer than W-stage ones, so M wins.
    always_comb begin
        o_fwd_a_e = FWD_W'(FWD_RF);
        o_fwd_b_e = FWD_W'(FWD_RF);
        if (i_rs_e != '0 && i_rs_e == i_wreg_m && i_regwr_m)
            o_fwd_a_e = FWD_W'(FWD_MEM);
        else if (i_rs_e != '0 && i_rs_e == i_wreg_w && i_regwr_w)
            o_fwd_a_e = FWD_W'(FWD_WB);
        if (i_rt_e != '0 && i_rt_e == i_wreg_m && i_regwr_m)
            o_fwd_b_e = FWD_W'(FWD_MEM);
        else if (i_rt_e != '0 && i_rt_e == i_wreg_w && i_regwr_w)
            o_fwd_b_e = FWD_W'(FWD_WB);
    end

    assign o_fwd_a_d = (i_rs_d != '0) && (i_rs_d == i_wreg_m) && i_regwr_m;
    assign o_fwd_b_d = (i_rt_d != '0) && (i_rt_d == i_wreg_m) && i_regwr_m;

    assign w_e_hits_d  = (i_wreg_e != '0) && (i_wreg_e == i_rs_d || i_wreg_e == i_rt_d);
    assign w_m_hits_d  = (i_wreg_m != '0) && (i_wreg_m == i_rs_d || i_wreg_m == i_rt_d);
    assign w_lw_stall  = i_mem2reg_e && w_e_hits_d;
    assign w_br_stall  = i_branch_d && ((i_regwr_e && w_e_hits_d) || (i_mem2reg_m && w_m_hits_d));
    assign w_mdu_stall = (i_hilo_rd_d || i_mdu_op_d) && (o_mdu_busy || i_mdu_start_e);
    assign w_stall_any = w_lw_stall || w_br_stall || w_mdu_stall;

    assign o_stall_f = w_stall_any;
    assign o_stall_d = w_stall_any;
    assign o_flush_e = w_stall_any;
    // A stalled branch is re-evaluated next cycle, so it must not redirect now.
    assign o_flush_d = i_pcsrc_d && !w_stall_any;

    mdu_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_mdu_start_e),
        .o_busy  (o_mdu_busy),
        .o_done  (o_mdu_done),
        .o_err   (o_mdu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall_any && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule
